// File: rtl/ovl_rd_ack_queue.sv
// Circular-buffer queue with a handshaked, fixed-latency read port.
// A read request is accepted in IDLE, waits ACK_LAT cycles, then pops one entry and pulses rd_ack.
module ovl_rd_ack_queue #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ACK_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic                     rd_ack,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = $clog2(ACK_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_q;
    logic [LW-1:0]      lat_q;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic               rd_ack_q;
    logic               overflow_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               full_w;
    logic               empty_w;
    logic               push;
    logic               accept;
    logic               pop;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign push    = wr_en && !full_w;
    assign accept  = (state_q == S_IDLE) && rd && !empty_w;

    // The pop edge is the edge that enters ACK: straight from IDLE when
    // ACK_LAT is 1, otherwise from WAIT once the latency counter hits 1.
    assign pop = (accept && (ACK_LAT == 1)) ||
                 ((state_q == S_WAIT) && (lat_q == LW'(1)));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= wr_en && full_w;
            rd_ack_q   <= pop;
            if (pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (ACK_LAT == 1) begin
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_WAIT;
                            lat_q   <= LW'(ACK_LAT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_q == LW'(1)) begin
                        state_q <= S_ACK;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ovl_rd_ack_queue.sv
// Directed bench for ovl_rd_ack_queue at default parameters (WIDTH=8, DEPTH=4, ACK_LAT=2).
module tb_ovl_rd_ack_queue;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       busy;

    int unsigned n_chk;
    int unsigned n_fail;

    ovl_rd_ack_queue #(.WIDTH(8), .DEPTH(4), .ACK_LAT(2)) dut (
        .clock    (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd       (rd),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  wdata;
        logic        rd;
        logic        ack;
        logic [7:0]  rdata;
        int unsigned cnt;
        logic        ovf;
        logic        busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic w, input logic [7:0] wd, input logic r,
                                input logic a, input logic [7:0] rdv, input int unsigned c,
                                input logic o, input logic b);
        vec_t v;
        v.wr = w; v.wdata = wd; v.rd = r; v.ack = a;
        v.rdata = rdv; v.cnt = c; v.ovf = o; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic a, input logic [7:0] d,
                           input int unsigned c, input logic o, input logic b);
        chk({tag, ".rd_ack"},   32'(rd_ack),   32'(a));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(d));
        chk({tag, ".count"},    32'(count),    c);
        chk({tag, ".empty"},    32'(empty),    32'(c == 0));
        chk({tag, ".full"},     32'(full),     32'(c == 4));
        chk({tag, ".overflow"}, 32'(overflow), 32'(o));
        chk({tag, ".busy"},     32'(busy),     32'(b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd      = 1'b0;

        // wr, wdata, rd | ack, rd_data, count, overflow, busy (outputs after the edge)
        vt.push_back(mk(1, 8'hA5, 0, 0, 8'h00, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 8'hA5, 0, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'hA5, 0, 0, 0));
        vt.push_back(mk(1, 8'h01, 0, 0, 8'hA5, 1, 0, 0));
        vt.push_back(mk(1, 8'h02, 0, 0, 8'hA5, 2, 0, 0));
        vt.push_back(mk(1, 8'h03, 0, 0, 8'hA5, 3, 0, 0));
        vt.push_back(mk(1, 8'h04, 0, 0, 8'hA5, 4, 0, 0));
        vt.push_back(mk(1, 8'h05, 0, 0, 8'hA5, 4, 1, 0));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'hA5, 4, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'hA5, 4, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 8'h01, 3, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h01, 3, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h01, 3, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 8'h02, 2, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'h02, 2, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h02, 2, 0, 1));
        vt.push_back(mk(1, 8'h06, 1, 1, 8'h03, 2, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h03, 2, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h03, 2, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 8'h04, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'h04, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h04, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 8'h06, 0, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'h06, 0, 0, 0));
        vt.push_back(mk(1, 8'h11, 0, 0, 8'h06, 1, 0, 0));
        vt.push_back(mk(1, 8'h12, 0, 0, 8'h06, 2, 0, 0));
        vt.push_back(mk(1, 8'h13, 0, 0, 8'h06, 3, 0, 0));
        vt.push_back(mk(1, 8'h14, 1, 0, 8'h06, 4, 0, 1));
        vt.push_back(mk(1, 8'h15, 1, 1, 8'h11, 3, 1, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'h11, 3, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h11, 3, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 8'h12, 2, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h12, 2, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h12, 2, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 1, 8'h13, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h13, 1, 0, 0));
        vt.push_back(mk(0, 8'h00, 1, 0, 8'h13, 1, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 8'h14, 0, 0, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 8'h14, 0, 0, 0));

        // Reset takes effect before any clock edge.
        #1;
        chk_all("reset", 1'b0, 8'h00, 0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            wr_en   = vt[i].wr;
            wr_data = vt[i].wdata;
            rd      = vt[i].rd;
            cyc();
            chk_all($sformatf("v%0d", i), vt[i].ack, vt[i].rdata, vt[i].cnt, vt[i].ovf, vt[i].busy);
        end

        // Request held on an empty queue is only accepted after data arrives.
        wr_en = 1'b0;
        rd    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_all($sformatf("emptyrd%0d", i), 1'b0, 8'h14, 0, 1'b0, 1'b0);
        end
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        cyc();
        chk_all("emptyrd.wr", 1'b0, 8'h14, 1, 1'b0, 1'b0);
        wr_en = 1'b0;
        cyc();
        chk_all("emptyrd.acc", 1'b0, 8'h14, 1, 1'b0, 1'b1);
        cyc();
        chk_all("emptyrd.ack", 1'b1, 8'h3C, 0, 1'b0, 1'b1);
        rd = 1'b0;
        cyc();
        chk_all("emptyrd.done", 1'b0, 8'h3C, 0, 1'b0, 1'b0);

        // Reset in WAIT drops the pending request and the stored entries.
        wr_en   = 1'b1;
        wr_data = 8'h77;
        cyc();
        wr_en = 1'b0;
        rd    = 1'b1;
        cyc();
        chk_all("rstwait.pre", 1'b0, 8'h3C, 1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("rstwait.async", 1'b0, 8'h00, 0, 1'b0, 1'b0);
        rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all($sformatf("rstwait.hold%0d", i), 1'b0, 8'h00, 0, 1'b0, 1'b0);
        end
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h88;
        cyc();
        chk_all("post.wr", 1'b0, 8'h00, 1, 1'b0, 1'b0);
        wr_en = 1'b0;
        rd    = 1'b1;
        cyc();
        chk_all("post.acc", 1'b0, 8'h00, 1, 1'b0, 1'b1);
        cyc();
        chk_all("post.ack", 1'b1, 8'h88, 0, 1'b0, 1'b1);
        rd = 1'b0;
        cyc();
        chk_all("post.done", 1'b0, 8'h88, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
